fir_decim_mac_sched: RTL and testbench
======================================

Name: fir_decim_mac_sched

Overview:
- Time-multiplexed MAC controller for one decimating FIR branch of the multirate filterbank.
- Accepts signed input samples into an NTAPS-deep delay line. After every DECIM-th accepted sample it sequences all taps through the single shared combinational 16s x 13ns multiplier and accumulates the products.
- Emits one full-precision filter output per DECIM inputs over a valid/ready stream.
- Coefficients come from an external combinational ROM, addressed by this block.

Parameters:
- NTAPS, 16, number of FIR taps (>=2).
- DECIM, 2, decimation factor (>=1); one output per DECIM accepted samples.
- DIN_W, 16, signed sample width.
- COEF_W, 13, unsigned coefficient width.
- PROD_W, 29, signed product width (DIN_W+COEF_W).
- ACC_W, 33, accumulator/output width (PROD_W+clog2(NTAPS)).

Ports:
- ap_clk  in  1  clock, rising edge.
- ap_rst  in  1  asynchronous active-high reset.
- s_data  in  DIN_W  signed input sample.
- s_valid  in  1  input sample valid.
- s_ready  out  1  block can accept a sample.
- coef_addr  out  clog2(NTAPS)  ROM address (tap index).
- coef_data  in  COEF_W  unsigned coefficient, combinational read of coef_addr.
- mul_a  out  DIN_W  multiplier operand 0 (signed sample).
- mul_b  out  COEF_W  multiplier operand 1 (unsigned coefficient).
- mul_p  in  PROD_W  multiplier result, combinational from mul_a/mul_b.
- m_data  out  ACC_W  signed filter output.
- m_valid  out  1  output valid.
- m_ready  in  1  downstream accepts output.
- busy  out  1  high in MAC, DRAIN or OUT.

Behaviour:
- Reset (async assert, sync release), all registers cleared:
  - state=IDLE; delay line x[0..NTAPS-1]=0; phase=0; k=0; acc=0; p_reg=0.
  - Outputs: s_ready=1, m_valid=0, m_data=0, busy=0, coef_addr=0, mul_a=0, mul_b=coef_data passthrough.
- IDLE:
  - s_ready=1. On s_valid&s_ready: x[i]<=x[i-1] for i>=1, x[0]<=s_data.
  - If phase==DECIM-1: phase<=0, k<=0, acc<=0, go to MAC. Otherwise phase<=phase+1 and stay in IDLE.
- MAC (NTAPS cycles):
  - s_ready=0. coef_addr=k, mul_a=x[k], mul_b=coef_data.
  - Each cycle: p_reg<=mul_p. If k>0: acc<=acc+sign_ext(p_reg). k<=k+1.
  - After k==NTAPS-1, go to DRAIN.
- DRAIN (1 cycle): acc<=acc+sign_ext(p_reg), m_data<=that sum, go to OUT.
- OUT:
  - m_valid=1. m_data is held stable until m_valid&m_ready; on that handshake, m_valid<=0 and go to IDLE.
  - No s_data is accepted until return to IDLE. Backpressure holds indefinitely.
- Arithmetic:
  - Product is signed sample times zero-extended coefficient.
  - Product is sign-extended to ACC_W.
  - No saturation or rounding; ACC_W guarantees no overflow for any input.
- Latency:
  - Handshake accepting the DECIM-th sample at edge E0 -> m_valid high from E0+NTAPS+2.
  - Minimum spacing between outputs is DECIM+NTAPS+2 cycles with m_ready held high.
- Boundaries:
  - DECIM=1: every accepted sample triggers MAC.
  - Sample-count phase is not advanced outside IDLE.
  - s_valid with s_ready=0 is ignored; upstream must hold the sample.
  - Reset mid-MAC/OUT clears the delay line and phase: m_valid drops immediately and the pending result is lost.
  - k wraps only via state exit, never beyond NTAPS-1.
- mul_a/coef_addr outside MAC are 0, which gives deterministic multiplier inputs.

Test Plan:
- Impulse, NTAPS=16, DECIM=2, coef[k]=k+1: send 1,0,0,0,... with m_ready=1 -> outputs 2,4,6,...,16, then 0,0.
- Extreme magnitude: all samples -32768, all coef 8191, 16 samples then 2 more -> output -4294443008 with no wrap. Same with +32767 -> 4294311952.
- Latency: DECIM-th sample accepted at cycle 10 -> m_valid first high at cycle 28. s_ready low for cycles 11..28 and while OUT is held.
- Backpressure: m_ready low 5 cycles after m_valid -> m_data stable, s_ready=0, busy=1. Release -> one handshake, then s_ready=1 next cycle.
- Reset mid-MAC (ap_rst asserted at k=7 for 2 cycles, asynchronously) -> m_valid=0, busy=0, s_ready=1 immediately. The next impulse test reproduces the first-test values from zero history.
- DECIM=1 build: stream of constant 1s with coef[k]=1 -> outputs 1,2,3,...,16,16,16.

Source files
------------

// File: rtl/fir_decim_mac_sched.sv
// Decimating FIR branch MAC controller: NTAPS-deep delay line, one output per DECIM
// accepted samples, taps sequenced through one shared external multiplier and coefficient ROM.
module fir_decim_mac_sched #(
  parameter int NTAPS  = 16,
  parameter int DECIM  = 2,
  parameter int DIN_W  = 16,
  parameter int COEF_W = 13,
  parameter int PROD_W = DIN_W + COEF_W,
  parameter int ACC_W  = PROD_W + $clog2(NTAPS)
) (
  input  logic                      ap_clk,
  input  logic                      ap_rst,
  input  logic [DIN_W-1:0]          s_data,
  input  logic                      s_valid,
  output logic                      s_ready,
  output logic [$clog2(NTAPS)-1:0]  coef_addr,
  input  logic [COEF_W-1:0]         coef_data,
  output logic [DIN_W-1:0]          mul_a,
  output logic [COEF_W-1:0]         mul_b,
  input  logic [PROD_W-1:0]         mul_p,
  output logic [ACC_W-1:0]          m_data,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic                      busy
);

  localparam int AW = $clog2(NTAPS);
  localparam int PW = (DECIM > 1) ? $clog2(DECIM) : 1;

  typedef enum logic [1:0] {IDLE, MAC, DRAIN, OUT} state_t;

  state_t             state_q, state_d;
  logic [DIN_W-1:0]   x_q [NTAPS];
  logic [DIN_W-1:0]   x_d [NTAPS];
  logic [PW-1:0]      phase_q, phase_d;
  logic [AW-1:0]      k_q, k_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [PROD_W-1:0]  p_q, p_d;
  logic [ACC_W-1:0]   m_data_q, m_data_d;
  logic               m_valid_q, m_valid_d;
  logic [ACC_W-1:0]   p_ext;
  logic [ACC_W-1:0]   sum;

  assign p_ext = {{(ACC_W-PROD_W){p_q[PROD_W-1]}}, p_q};
  assign sum   = acc_q + p_ext;

  assign s_ready   = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign coef_addr = (state_q == MAC) ? k_q : '0;
  assign mul_a     = (state_q == MAC) ? x_q[k_q] : '0;
  assign mul_b     = coef_data;
  assign m_data    = m_data_q;
  assign m_valid   = m_valid_q;

  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    phase_d   = phase_q;
    k_d       = k_q;
    acc_d     = acc_q;
    p_d       = p_q;
    m_data_d  = m_data_q;
    m_valid_d = m_valid_q;
    case (state_q)
      IDLE: begin
        if (s_valid) begin
          for (int unsigned i = 1; i < NTAPS; i++) x_d[i] = x_q[i-1];
          x_d[0] = s_data;
          if (phase_q == PW'(DECIM-1)) begin
            phase_d = '0;
            k_d     = '0;
            acc_d   = '0;
            state_d = MAC;
          end else begin
            phase_d = phase_q + PW'(1);
          end
        end
      end
      MAC: begin
        // product is registered, so accumulation trails the tap index by one cycle
        p_d = mul_p;
        if (k_q != '0) acc_d = sum;
        if (k_q == AW'(NTAPS-1)) state_d = DRAIN;
        else                     k_d     = k_q + AW'(1);
      end
      DRAIN: begin
        acc_d     = sum;
        m_data_d  = sum;
        m_valid_d = 1'b1;
        state_d   = OUT;
      end
      OUT: begin
        if (m_ready) begin
          m_valid_d = 1'b0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      state_q <= IDLE;
      for (int unsigned i = 0; i < NTAPS; i++) x_q[i] <= '0;
      phase_q   <= '0;
      k_q       <= '0;
      acc_q     <= '0;
      p_q       <= '0;
      m_data_q  <= '0;
      m_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      phase_q   <= phase_d;
      k_q       <= k_d;
      acc_q     <= acc_d;
      p_q       <= p_d;
      m_data_q  <= m_data_d;
      m_valid_q <= m_valid_d;
    end
  end

endmodule

// File: tb/tb_fir_decim_mac_sched.sv
// Directed bench for fir_decim_mac_sched: DECIM=2 instance plus a DECIM=1 instance,
// with behavioural coefficient ROM and multiplier models.
module tb_fir_decim_mac_sched;

  logic        ap_clk = 1'b0;
  logic        ap_rst;
  always #5 ap_clk = ~ap_clk;

  logic [15:0] s_data;
  logic        s_valid, s_ready;
  logic [3:0]  coef_addr;
  logic [12:0] coef_data, mul_b;
  logic [15:0] mul_a;
  logic [28:0] mul_p;
  logic [32:0] m_data;
  logic        m_valid, m_ready, busy;

  logic [15:0] s1_data;
  logic        s1_valid, s1_ready;
  logic [3:0]  coef1_addr;
  logic [12:0] coef1_data, mul1_b;
  logic [15:0] mul1_a;
  logic [28:0] mul1_p;
  logic [32:0] m1_data;
  logic        m1_valid, m1_ready, busy1;

  int coef_mode;
  int errors = 0;
  int checks = 0;

  always_comb begin
    case (coef_mode)
      0:       coef_data = 13'(coef_addr) + 13'd1;
      1:       coef_data = 13'd8191;
      default: coef_data = 13'd1;
    endcase
  end
  assign coef1_data = 13'd1;

  logic signed [28:0] a_ext, b_ext, a1_ext, b1_ext;
  always_comb begin
    a_ext  = 29'($signed(mul_a));
    b_ext  = 29'({1'b0, mul_b});
    mul_p  = a_ext * b_ext;
    a1_ext = 29'($signed(mul1_a));
    b1_ext = 29'({1'b0, mul1_b});
    mul1_p = a1_ext * b1_ext;
  end

  fir_decim_mac_sched #(.NTAPS(16), .DECIM(2)) dut (
    .ap_clk(ap_clk), .ap_rst(ap_rst),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .coef_addr(coef_addr), .coef_data(coef_data),
    .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .busy(busy)
  );

  fir_decim_mac_sched #(.NTAPS(16), .DECIM(1)) dut_d1 (
    .ap_clk(ap_clk), .ap_rst(ap_rst),
    .s_data(s1_data), .s_valid(s1_valid), .s_ready(s1_ready),
    .coef_addr(coef1_addr), .coef_data(coef1_data),
    .mul_a(mul1_a), .mul_b(mul1_b), .mul_p(mul1_p),
    .m_data(m1_data), .m_valid(m1_valid), .m_ready(m1_ready), .busy(busy1)
  );

  task automatic send_sample(input logic [15:0] v);
    int n = 0;
    s_data  = v;
    s_valid = 1'b1;
    @(negedge ap_clk);
    while (!s_ready && n < 200) begin n++; @(negedge ap_clk); end
    if (!s_ready) begin
      checks++; errors++;
      $display("FAIL send_timeout: s_ready=%0b required 1", s_ready);
    end
    @(posedge ap_clk); #1;
    s_valid = 1'b0;
  endtask

  task automatic get_output(output logic [32:0] v);
    int n = 0;
    @(negedge ap_clk);
    while (!m_valid && n < 200) begin n++; @(negedge ap_clk); end
    if (!m_valid) begin
      checks++; errors++;
      $display("FAIL out_timeout: m_valid=%0b required 1", m_valid);
    end
    v = m_data;
    @(posedge ap_clk); #1;
  endtask

  task automatic send_sample1(input logic [15:0] v);
    int n = 0;
    s1_data  = v;
    s1_valid = 1'b1;
    @(negedge ap_clk);
    while (!s1_ready && n < 200) begin n++; @(negedge ap_clk); end
    if (!s1_ready) begin
      checks++; errors++;
      $display("FAIL send1_timeout: s_ready=%0b required 1", s1_ready);
    end
    @(posedge ap_clk); #1;
    s1_valid = 1'b0;
  endtask

  task automatic get_output1(output logic [32:0] v);
    int n = 0;
    @(negedge ap_clk);
    while (!m1_valid && n < 200) begin n++; @(negedge ap_clk); end
    if (!m1_valid) begin
      checks++; errors++;
      $display("FAIL out1_timeout: m_valid=%0b required 1", m1_valid);
    end
    v = m1_data;
    @(posedge ap_clk); #1;
  endtask

  task automatic test_reset();
    ap_rst = 1'b1; coef_mode = 0;
    s_valid = 1'b0; s_data = '0; m_ready = 1'b1;
    s1_valid = 1'b0; s1_data = '0; m1_ready = 1'b1;
    repeat (3) @(posedge ap_clk);
    @(negedge ap_clk); ap_rst = 1'b0;
    @(negedge ap_clk);
    checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL rst_s_ready: got %b want 1", s_ready); end
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL rst_m_valid: got %b want 0", m_valid); end
    checks++; if (m_data !== 33'd0) begin errors++; $display("FAIL rst_m_data: got %0d want 0", m_data); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
    checks++; if (coef_addr !== 4'd0) begin errors++; $display("FAIL rst_coef_addr: got %0d want 0", coef_addr); end
    checks++; if (mul_a !== 16'd0) begin errors++; $display("FAIL rst_mul_a: got %0d want 0", mul_a); end
    checks++; if (mul_b !== 13'd1) begin errors++; $display("FAIL rst_mul_b: got %0d want 1", mul_b); end
    checks++; if (s1_ready !== 1'b1 || busy1 !== 1'b0 || m1_valid !== 1'b0 || coef1_addr !== 4'd0) begin
      errors++; $display("FAIL rst_d1: s_ready=%b busy=%b m_valid=%b coef_addr=%0d want 1 0 0 0",
                         s1_ready, busy1, m1_valid, coef1_addr);
    end
    @(posedge ap_clk); #1;
  endtask

  task automatic test_impulse(input string tag);
    logic [32:0] v;
    longint exp;
    coef_mode = 0; m_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      send_sample((i == 0) ? 16'd1 : 16'd0);
      send_sample(16'd0);
      get_output(v);
      exp = (i < 8) ? longint'(2 * (i + 1)) : 64'sd0;
      checks++;
      if (longint'($signed(v)) !== exp) begin
        errors++; $display("FAIL %s_out%0d: got %0d want %0d", tag, i, $signed(v), exp);
      end
    end
  endtask

  task automatic test_extreme();
    logic [32:0] v;
    coef_mode = 1; m_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      send_sample(16'h8000); send_sample(16'h8000);
      get_output(v);
      if (i >= 7) begin
        checks++;
        if (longint'($signed(v)) !== -64'sd4294443008) begin
          errors++; $display("FAIL extreme_neg%0d: got %0d want -4294443008", i, $signed(v));
        end
      end
    end
    for (int i = 0; i < 9; i++) begin
      send_sample(16'h7FFF); send_sample(16'h7FFF);
      get_output(v);
      if (i >= 7) begin
        checks++;
        if (longint'($signed(v)) !== 64'sd4294311952) begin
          errors++; $display("FAIL extreme_pos%0d: got %0d want 4294311952", i, $signed(v));
        end
      end
    end
  endtask

  task automatic test_latency();
    int first = -1;
    logic bad_ready = 1'b0;
    coef_mode = 0; m_ready = 1'b1;
    send_sample(16'd5);
    s_data = 16'd7; s_valid = 1'b1;
    @(negedge ap_clk);
    checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL lat_accept: s_ready=%b want 1", s_ready); end
    @(posedge ap_clk); #1; s_valid = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge ap_clk);
      if (s_ready !== 1'b0) bad_ready = 1'b1;
      if (m_valid === 1'b1) begin first = n; break; end
    end
    checks++; if (first != 18) begin errors++; $display("FAIL lat_cycles: got %0d want 18", first); end
    checks++; if (bad_ready) begin errors++; $display("FAIL lat_s_ready_low: got 1 during busy want 0"); end
    @(posedge ap_clk); #1;
    @(negedge ap_clk);
    checks++; if (s_ready !== 1'b1 || m_valid !== 1'b0) begin
      errors++; $display("FAIL lat_return: s_ready=%b m_valid=%b want 1 0", s_ready, m_valid);
    end
    @(posedge ap_clk); #1;
  endtask

  task automatic test_backpressure();
    logic [32:0] v, v0;
    int n = 0;
    coef_mode = 0; m_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin send_sample(16'd0); send_sample(16'd0); get_output(v); end
    m_ready = 1'b0;
    send_sample(16'd3); send_sample(16'd4);
    @(negedge ap_clk);
    while (!m_valid && n < 100) begin n++; @(negedge ap_clk); end
    v0 = m_data;
    checks++; if (m_valid !== 1'b1 || v0 !== 33'd10) begin
      errors++; $display("FAIL bp_first: m_valid=%b m_data=%0d want 1 10", m_valid, v0);
    end
    @(posedge ap_clk); #1;
    s_data = 16'h1234; s_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge ap_clk);
      checks++;
      if (m_data !== v0 || m_valid !== 1'b1 || s_ready !== 1'b0 || busy !== 1'b1) begin
        errors++; $display("FAIL bp_hold%0d: m_data=%0d m_valid=%b s_ready=%b busy=%b want %0d 1 0 1",
                           i, m_data, m_valid, s_ready, busy, v0);
      end
    end
    @(posedge ap_clk); #1;
    s_valid = 1'b0; m_ready = 1'b1;
    @(negedge ap_clk);
    checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL bp_pre_hs: m_valid=%b want 1", m_valid); end
    @(posedge ap_clk); #1;
    @(negedge ap_clk);
    checks++; if (m_valid !== 1'b0 || s_ready !== 1'b1) begin
      errors++; $display("FAIL bp_post_hs: m_valid=%b s_ready=%b want 0 1", m_valid, s_ready);
    end
    @(posedge ap_clk); #1;
    send_sample(16'd0); send_sample(16'd0);
    get_output(v);
    checks++; if (v !== 33'd24) begin errors++; $display("FAIL bp_ignored_sample: got %0d want 24", v); end
  endtask

  task automatic test_reset_mid_mac();
    int n = 0;
    coef_mode = 0; m_ready = 1'b1;
    send_sample(16'd100); send_sample(16'd200);
    @(negedge ap_clk);
    while (!(busy && coef_addr == 4'd7) && n < 100) begin n++; @(negedge ap_clk); end
    checks++; if (coef_addr !== 4'd7) begin errors++; $display("FAIL rmid_reach_k7: got %0d want 7", coef_addr); end
    #2 ap_rst = 1'b1;
    #1;
    checks++; if (m_valid !== 1'b0 || busy !== 1'b0 || s_ready !== 1'b1 || coef_addr !== 4'd0) begin
      errors++; $display("FAIL rmid_async: m_valid=%b busy=%b s_ready=%b coef_addr=%0d want 0 0 1 0",
                         m_valid, busy, s_ready, coef_addr);
    end
    @(posedge ap_clk); @(posedge ap_clk);
    @(negedge ap_clk); ap_rst = 1'b0;
    @(posedge ap_clk); #1;
    test_impulse("rmid_impulse");
  endtask

  task automatic test_decim1();
    logic [32:0] v;
    longint exp;
    m1_ready = 1'b1;
    for (int i = 0; i < 19; i++) begin
      send_sample1(16'd1);
      get_output1(v);
      exp = (i < 16) ? longint'(i + 1) : 64'sd16;
      checks++;
      if (longint'($signed(v)) !== exp) begin
        errors++; $display("FAIL decim1_out%0d: got %0d want %0d", i, $signed(v), exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_impulse("impulse");
    test_extreme();
    test_latency();
    test_backpressure();
    test_reset_mid_mac();
    test_decim1();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
